sam_rv32i: RTL and testbench

SAM_RV32I -- requirements
Module: sam_rv32i

---
 rtl/sam_rv32i.sv | 181 ++++++++++++++++++
 tb/tb_sam_rv32i.sv | 114 +++++++++++
 2 files changed

// File: rtl/sam_rv32i.sv
// Single-cycle RV32I subset core with internal 32-word instruction ROM,
// 32-word data memory and a registered copy of the last register write-back.
module sam_rv32i (
    input  logic        clk,
    input  logic        RN,
    output logic [31:0] NPC,
    output logic [31:0] WB_OUT
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NMEM  = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [XLEN-1:0] npc_q, npc_d;
    logic [XLEN-1:0] wb_q, wb_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    logic [XLEN-1:0] dm_q [NMEM];
    logic [XLEN-1:0] dm_d [NMEM];

    function automatic logic [31:0] rom_word(input logic [4:0] idx);
        case (idx)
            5'd0:    rom_word = 32'h0050_0093; // ADDI x1,x0,5
            5'd1:    rom_word = 32'h0030_0113; // ADDI x2,x0,3
            5'd2:    rom_word = 32'h0020_81B3; // ADD  x3,x1,x2
            5'd3:    rom_word = 32'h4020_8233; // SUB  x4,x1,x2
            5'd4:    rom_word = 32'h0030_2023; // SW   x3,0(x0)
            5'd5:    rom_word = 32'h0000_2283; // LW   x5,0(x0)
            5'd6:    rom_word = 32'h0051_8463; // BEQ  x3,x5,+8
            5'd7:    rom_word = 32'h0010_0313; // ADDI x6,x0,1
            5'd8:    rom_word = 32'h0020_E333; // OR   x6,x1,x2
            5'd9:    rom_word = 32'h0020_F3B3; // AND  x7,x1,x2
            5'd10:   rom_word = 32'h0000_006F; // JAL  x0,0
            default: rom_word = 32'h0000_0013; // NOP
        endcase
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [XLEN-1:0] op_b, alu_res, mem_addr;
    logic [4:0]      shamt, mem_idx;
    logic            is_r, alt, alu_legal, wr_en;
    logic [XLEN-1:0] wr_val;

    assign instr   = rom_word(npc_q[6:2]);
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign is_r  = (opcode == OP_R);
    assign alt   = (funct7 == F7_ALT);
    assign op_b  = is_r ? rs2_val : imm_i;
    assign shamt = op_b[4:0];

    assign mem_addr = rs1_val + ((opcode == OP_SW) ? imm_s : imm_i);
    assign mem_idx  = 5'(mem_addr >> 2);

    // Shared ALU for R-type and OP-IMM; funct7 only qualifies SUB/SRA/SRAI and shifts.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b0;
        case (funct3)
            3'b000: begin
                alu_res   = (is_r && alt) ? rs1_val - op_b : rs1_val + op_b;
                alu_legal = !is_r || funct7 == 7'd0 || alt;
            end
            3'b001: begin
                alu_res   = rs1_val << shamt;
                alu_legal = (funct7 == 7'd0);
            end
            3'b010: begin
                alu_res   = {31'b0, $signed(rs1_val) < $signed(op_b)};
                alu_legal = !is_r || funct7 == 7'd0;
            end
            3'b011: begin
                alu_res   = {31'b0, rs1_val < op_b};
                alu_legal = is_r && funct7 == 7'd0;
            end
            3'b100: begin
                alu_res   = rs1_val ^ op_b;
                alu_legal = !is_r || funct7 == 7'd0;
            end
            3'b101: begin
                alu_res   = alt ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
                alu_legal = funct7 == 7'd0 || alt;
            end
            3'b110: begin
                alu_res   = rs1_val | op_b;
                alu_legal = !is_r || funct7 == 7'd0;
            end
            default: begin
                alu_res   = rs1_val & op_b;
                alu_legal = !is_r || funct7 == 7'd0;
            end
        endcase
    end

    // Execute / next-state; unsupported encodings fall through as NOP.
    always_comb begin
        npc_d  = npc_q + 32'd4;
        wb_d   = wb_q;
        rf_d   = rf_q;
        dm_d   = dm_q;
        wr_en  = 1'b0;
        wr_val = '0;
        case (opcode)
            OP_R, OP_I: begin
                wr_en  = alu_legal;
                wr_val = alu_res;
            end
            OP_LW: begin
                wr_en  = (funct3 == 3'b010);
                wr_val = dm_q[mem_idx];
            end
            OP_SW: begin
                if (funct3 == 3'b010) dm_d[mem_idx] = rs2_val;
            end
            OP_BR: begin
                if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
                    (funct3 == 3'b001 && rs1_val != rs2_val))
                    npc_d = npc_q + imm_b;
            end
            OP_JAL: begin
                wr_en  = 1'b1;
                wr_val = npc_q + 32'd4;
                npc_d  = npc_q + imm_j;
            end
            OP_LUI: begin
                wr_en  = 1'b1;
                wr_val = imm_u;
            end
            default: ;
        endcase
        if (wr_en && rd != 5'd0) begin
            rf_d[rd] = wr_val;
            wb_d     = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (RN) begin
            npc_q <= '0;
            wb_q  <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
                dm_q[i] <= '0;
            end
        end else begin
            npc_q <= npc_d;
            wb_q  <= wb_d;
            rf_q  <= rf_d;
            dm_q  <= dm_d;
        end
    end

    assign NPC    = npc_q;
    assign WB_OUT = wb_q;
endmodule

// File: tb/tb_sam_rv32i.sv
// Scoreboard bench for sam_rv32i: expected architectural trace of the ROM
// program is queued per edge and compared by an independent monitor.
module tb_sam_rv32i;
    logic        clk;
    logic        RN;
    logic [31:0] NPC;
    logic [31:0] WB_OUT;

    sam_rv32i dut (.clk(clk), .RN(RN), .NPC(NPC), .WB_OUT(WB_OUT));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] wb;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   steps  = 0;   // edges executed since the last reset edge
    bit   stim_done = 1'b0;

    // Program outcome after k instruction edges, derived from the program text:
    // x1=5, x2=3, x3=8, x4=2, SW, LW x5=8, BEQ taken to 32, OR=7, AND=1, JAL self-loop.
    function automatic exp_t trace(input int k);
        exp_t e;
        e.tag = $sformatf("step%0d", k);
        case (k)
            1: begin e.npc = 4;  e.wb = 5; end
            2: begin e.npc = 8;  e.wb = 3; end
            3: begin e.npc = 12; e.wb = 8; end
            4: begin e.npc = 16; e.wb = 2; end
            5: begin e.npc = 20; e.wb = 2; end
            6: begin e.npc = 24; e.wb = 8; end
            7: begin e.npc = 32; e.wb = 8; end
            8: begin e.npc = 36; e.wb = 7; end
            default: begin e.npc = 40; e.wb = 1; end
        endcase
        return e;
    endfunction

    task automatic drive_edge(input bit rst);
        exp_t e;
        RN = rst;
        if (rst) begin
            steps = 0;
            e.npc = 0;
            e.wb  = 0;
            e.tag = "reset";
        end else begin
            steps++;
            e = trace(steps);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per edge, sampled well after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (NPC !== e.npc) begin
                    errors++;
                    $display("FAIL %s NPC: got %0d expected %0d", e.tag, NPC, e.npc);
                end
                checks++;
                if (WB_OUT !== e.wb) begin
                    errors++;
                    $display("FAIL %s WB_OUT: got %0d expected %0d", e.tag, WB_OUT, e.wb);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        RN = 1'b1;
        // Reset held several edges, then a full run including 100+ loop cycles.
        for (int i = 0; i < 3; i++) drive_edge(1'b1);
        for (int i = 0; i < 115; i++) drive_edge(1'b0);
        // Reset at cycle 7 of a fresh run, then the program must replay.
        drive_edge(1'b1);
        for (int i = 0; i < 7; i++) drive_edge(1'b0);
        drive_edge(1'b1);
        for (int i = 0; i < 20; i++) drive_edge(1'b0);
        // Random reset injection.
        for (int i = 0; i < 400; i++) drive_edge($urandom_range(0, 15) == 0);
        drive_edge(1'b0);

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
